// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake bundle for uart_tx_fifo: valid/ready plus the data word.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] d_in;

  modport master (output tx_valid, output d_in, input tx_ready);
  modport slave  (input tx_valid, input d_in, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO. Frames are start, DATA_BITS data bits
// LSB-first, optional even/odd parity, then one or two stop bits. Bit timing
// advances on an external baud tick, OVERSAMPLE ticks per bit.
module uart_tx_fifo #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            b_tick,
  uart_tx_fifo_if.slave                   wr,
  input  logic [1:0]                      parity_mode,
  input  logic                            stop2,
  output logic                            tx,
  output logic                            tx_done,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_n;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] shift;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 par_en_l, stop2_l, parity_bit;
  logic                 push, pop, bit_end, last_data, last_stop;

  assign wr.tx_ready = (fifo_count < CW'(FIFO_DEPTH));
  assign push        = wr.tx_valid && wr.tx_ready;
  assign pop         = (state == IDLE) && (fifo_count != '0);
  assign bit_end     = b_tick && (tick_cnt == TW'(OVERSAMPLE - 1));
  assign last_data   = (bit_cnt == BW'(DATA_BITS - 1));
  assign last_stop   = (bit_cnt == BW'(stop2_l));

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr.d_in;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state selection from the current bit position and latched framing.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pop) state_n = START;
      START:   if (bit_end) state_n = DATA;
      DATA:    if (bit_end && last_data) state_n = par_en_l ? PARITY : STOP;
      PARITY:  if (bit_end) state_n = STOP;
      STOP:    if (bit_end && last_stop) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: pop and latch framing in IDLE, then shift out bits on each bit end.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_en_l   <= 1'b0;
      stop2_l    <= 1'b0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
        tx       <= 1'b1;
        if (pop) begin
          shift      <= mem[rd_ptr];
          par_en_l   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
          stop2_l    <= stop2;
          parity_bit <= (^mem[rd_ptr]) ^ (parity_mode == 2'b10);
          tx         <= 1'b0;
        end
      end else if (b_tick) begin
        if (!bit_end) begin
          tick_cnt <= tick_cnt + TW'(1);
        end else begin
          tick_cnt <= '0;
          case (state)
            START: tx <= shift[0];
            DATA: begin
              shift <= shift >> 1;
              if (last_data) begin
                bit_cnt <= '0;
                tx      <= par_en_l ? parity_bit : 1'b1;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
                tx      <= shift[1];
              end
            end
            PARITY: begin
              bit_cnt <= '0;
              tx      <= 1'b1;
            end
            STOP: begin
              tx <= 1'b1;
              if (last_stop) tx_done <= 1'b1;
              else           bit_cnt <= bit_cnt + BW'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Status outputs derived from registered state.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed framing scenarios plus randomized traffic
// compared cycle-by-cycle against a frame-level reference model.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, bt_a, st2_a, tx_a, done_a, busy_a;
  logic [1:0] par_a;
  logic [2:0] cnt_a;
  uart_tx_fifo_if #(.DATA_BITS(8)) ifa ();

  uart_tx_fifo #(.OVERSAMPLE(16), .DATA_BITS(8), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(rst_a), .b_tick(bt_a), .wr(ifa),
    .parity_mode(par_a), .stop2(st2_a),
    .tx(tx_a), .tx_done(done_a), .busy(busy_a), .fifo_count(cnt_a)
  );

  logic       rst_b, bt_b, st2_b, tx_b, done_b, busy_b;
  logic [1:0] par_b;
  logic [2:0] cnt_b;
  uart_tx_fifo_if #(.DATA_BITS(7)) ifb ();

  uart_tx_fifo #(.OVERSAMPLE(16), .DATA_BITS(7), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(rst_b), .b_tick(bt_b), .wr(ifb),
    .parity_mode(par_b), .stop2(st2_b),
    .tx(tx_b), .tx_done(done_b), .busy(busy_b), .fifo_count(cnt_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model for dut_a: a word queue, plus the bit list of the frame
  // being sent and a count of baud ticks within the current bit.
  logic [7:0] mq[$];
  logic       fb [12];
  int         m_nbits, m_bi, m_tc;
  logic       m_active = 1'b0;
  logic       m_tx     = 1'b1;
  logic       m_done   = 1'b0;

  // Advance model by one clock using the inputs present before the edge, then clock.
  task automatic step_a();
    logic       do_push;
    logic [7:0] w;
    do_push = ifa.tx_valid && (mq.size() < 4);
    if (rst_a) begin
      mq.delete();
      m_active = 1'b0;
      m_tx     = 1'b1;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        if (mq.size() != 0) begin
          w = mq.pop_front();
          fb[0] = 1'b0;
          for (int i = 0; i < 8; i++) fb[1+i] = w[i];
          m_nbits = 9;
          if (par_a == 2'b01 || par_a == 2'b10) begin
            fb[m_nbits] = (($countones(w) % 2) == 1) ^ (par_a == 2'b10);
            m_nbits++;
          end
          fb[m_nbits] = 1'b1;
          m_nbits++;
          if (st2_a) begin
            fb[m_nbits] = 1'b1;
            m_nbits++;
          end
          m_active = 1'b1;
          m_bi     = 0;
          m_tc     = 0;
          m_tx     = 1'b0;
        end
      end else if (bt_a) begin
        m_tc++;
        if (m_tc == 16) begin
          m_tc = 0;
          m_bi++;
          if (m_bi == m_nbits) begin
            m_active = 1'b0;
            m_done   = 1'b1;
            m_tx     = 1'b1;
          end else begin
            m_tx = fb[m_bi];
          end
        end
      end
      if (do_push) mq.push_back(ifa.d_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    step_a();
    step_a();
    rst_a = 1'b0;
    rst_b = 1'b0;
    total++; if (tx_a !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    total++; if (ifa.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ifa.tx_ready); end
    total++; if (cnt_a !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cnt_a); end
    total++; if (tx_b !== 1'b1 || cnt_b !== 3'd0) begin
      bad++; $display("FAIL reset_b got tx=%b cnt=%0d want tx=1 cnt=0", tx_b, cnt_b);
    end
  endtask

  task automatic test_frame_a5();
    logic [9:0] expb, obs;
    int         done_at;
    logic       busy_ok;
    expb    = 10'b1101001010;
    obs     = '0;
    done_at = -1;
    busy_ok = 1'b1;
    par_a = 2'b00; st2_a = 1'b0; bt_a = 1'b1;
    ifa.d_in = 8'hA5; ifa.tx_valid = 1'b1;
    step_a();
    ifa.tx_valid = 1'b0;
    step_a();
    total++; if (tx_a !== 1'b0) begin bad++; $display("FAIL a5_fall got=%b want=0", tx_a); end
    for (int c = 0; c <= 200; c++) begin
      if (c < 160 && busy_a !== 1'b1) busy_ok = 1'b0;
      if (c < 160 && (c % 16) == 8) obs[c/16] = tx_a;
      if (done_a === 1'b1 && done_at < 0) done_at = c;
      step_a();
    end
    total++; if (obs !== expb) begin bad++; $display("FAIL a5_bits got=%b want=%b", obs, expb); end
    total++; if (done_at != 160) begin bad++; $display("FAIL a5_done_time got=%0d want=160", done_at); end
    total++; if (!busy_ok) begin bad++; $display("FAIL a5_busy got=dropped want=held"); end
  endtask

  task automatic test_parity();
    logic pobs, pexp;
    int   done_at;
    for (int i = 0; i < 2; i++) begin
      par_a   = (i == 0) ? 2'b01 : 2'b10;
      pexp    = (i == 0) ? 1'b1 : 1'b0;
      pobs    = 1'bx;
      done_at = -1;
      ifa.d_in = 8'h07; ifa.tx_valid = 1'b1;
      step_a();
      ifa.tx_valid = 1'b0;
      step_a();
      for (int c = 0; c <= 220; c++) begin
        if (c == 16*9 + 8) pobs = tx_a;
        if (done_a === 1'b1 && done_at < 0) done_at = c;
        step_a();
      end
      total++; if (pobs !== pexp) begin bad++; $display("FAIL parity_bit mode=%0d got=%b want=%b", par_a, pobs, pexp); end
      total++; if (done_at != 176) begin bad++; $display("FAIL parity_len mode=%0d got=%0d want=176", par_a, done_at); end
    end
    par_a = 2'b00;
  endtask

  task automatic test_dbits7();
    logic [10:0] expb, obs;
    int          done_at;
    logic        fell;
    expb    = 11'b11110101010;
    obs     = '0;
    done_at = -1;
    fell    = 1'b0;
    par_b = 2'b10; st2_b = 1'b1;
    for (int c = 0; c <= 760; c++) begin
      ifb.tx_valid = (c == 0);
      ifb.d_in     = 7'h55;
      bt_b         = (c >= 5) && (((c - 1) % 4) == 0);
      step_a();
      if (c == 1) fell = (tx_b === 1'b0);
      if (c >= 33 && c <= 33 + 640 && ((c - 33) % 64) == 0) obs[(c-33)/64] = tx_b;
      if (done_b === 1'b1 && done_at < 0) done_at = c;
    end
    bt_b = 1'b0;
    total++; if (!fell) begin bad++; $display("FAIL d7_fall got=%b want=0", tx_b); end
    total++; if (obs !== expb) begin bad++; $display("FAIL d7_bits got=%b want=%b", obs, expb); end
    total++; if (done_at != 705) begin bad++; $display("FAIL d7_frame_clk got=%0d want=704", done_at - 1); end
  endtask

  task automatic test_fifo_fill();
    int   idx, acc6_at, ndone, first_done, last_done;
    logic acc;
    idx = 0; acc6_at = -1; ndone = 0; first_done = -1; last_done = -1;
    bt_a = 1'b1; par_a = 2'b00; st2_a = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      ifa.tx_valid = (idx < 6);
      ifa.d_in     = 8'(idx + 1);
      acc = ifa.tx_valid && ifa.tx_ready;
      step_a();
      if (acc) begin
        idx++;
        if (idx == 5) begin
          total++; if (cnt_a !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", cnt_a); end
        end
        if (idx == 6) acc6_at = c;
      end
      if (c == 5) begin
        total++; if (ifa.tx_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b want=0", ifa.tx_ready); end
      end
      if (done_a === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = c;
        last_done = c;
      end
      total++;
      if ({tx_a, done_a, busy_a, ifa.tx_ready, cnt_a} !== {m_tx, m_done, m_active, (mq.size() < 4), 3'(mq.size())}) begin
        bad++;
        $display("FAIL fill_model c=%0d got=%b want=%b", c, {tx_a, done_a, busy_a, ifa.tx_ready, cnt_a},
                 {m_tx, m_done, m_active, (mq.size() < 4), 3'(mq.size())});
      end
    end
    ifa.tx_valid = 1'b0;
    total++; if (acc6_at != 163) begin bad++; $display("FAIL fill_accept6 got=%0d want=163", acc6_at); end
    total++; if (first_done != 161) begin bad++; $display("FAIL fill_first_done got=%0d want=161", first_done); end
    total++; if (ndone != 6 || last_done != 966) begin
      bad++; $display("FAIL fill_frames got=%0d@%0d want=6@966", ndone, last_done);
    end
  endtask

  task automatic test_config_change();
    int d1, d2;
    d1 = -1; d2 = -1;
    par_a = 2'b00; st2_a = 1'b0; bt_a = 1'b1;
    for (int c = 0; c <= 500; c++) begin
      ifa.tx_valid = (c == 0) || (c == 50);
      ifa.d_in     = 8'($urandom);
      if (c == 50) begin par_a = 2'b01; st2_a = 1'b1; end
      step_a();
      if (done_a === 1'b1) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      total++;
      if ({tx_a, done_a, busy_a, cnt_a} !== {m_tx, m_done, m_active, 3'(mq.size())}) begin
        bad++;
        $display("FAIL cfg_model c=%0d got=%b want=%b", c, {tx_a, done_a, busy_a, cnt_a},
                 {m_tx, m_done, m_active, 3'(mq.size())});
      end
    end
    ifa.tx_valid = 1'b0;
    par_a = 2'b00; st2_a = 1'b0;
    total++; if (d1 != 161) begin bad++; $display("FAIL cfg_first_done got=%0d want=161", d1); end
    total++; if (d2 != 354) begin bad++; $display("FAIL cfg_second_done got=%0d want=354", d2); end
  endtask

  task automatic test_reset_mid();
    logic saw_done, tx_low, busy_seen;
    saw_done = 1'b0; tx_low = 1'b0; busy_seen = 1'b0;
    bt_a = 1'b1;
    for (int c = 0; c <= 500; c++) begin
      ifa.tx_valid = (c < 3);
      ifa.d_in     = 8'($urandom);
      rst_a        = (c == 73);
      step_a();
      if (c == 72) begin
        total++; if (cnt_a !== 3'd2) begin bad++; $display("FAIL rmid_queued got=%0d want=2", cnt_a); end
      end
      if (c == 73) begin
        total++; if (tx_a !== 1'b1) begin bad++; $display("FAIL rmid_tx got=%b want=1", tx_a); end
        total++; if (cnt_a !== 3'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", cnt_a); end
      end
      if (c >= 73) begin
        if (done_a !== 1'b0) saw_done = 1'b1;
        if (tx_a !== 1'b1) tx_low = 1'b1;
        if (busy_a !== 1'b0) busy_seen = 1'b1;
      end
    end
    rst_a = 1'b0;
    total++; if (saw_done) begin bad++; $display("FAIL rmid_done got=pulse want=none"); end
    total++; if (tx_low || busy_seen) begin
      bad++; $display("FAIL rmid_idle got tx_low=%b busy=%b want 0 0", tx_low, busy_seen);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      bt_a         = ($urandom_range(0, 2) != 0);
      ifa.tx_valid = ($urandom_range(0, 3) == 0);
      ifa.d_in     = 8'($urandom);
      if ($urandom_range(0, 99) == 0) par_a = 2'($urandom);
      if ($urandom_range(0, 99) == 0) st2_a = 1'($urandom);
      rst_a = ($urandom_range(0, 1499) == 0);
      step_a();
      total++;
      if ({tx_a, done_a, busy_a, ifa.tx_ready, cnt_a} !== {m_tx, m_done, m_active, (mq.size() < 4), 3'(mq.size())}) begin
        bad++;
        $display("FAIL rand_model c=%0d got=%b want=%b", c, {tx_a, done_a, busy_a, ifa.tx_ready, cnt_a},
                 {m_tx, m_done, m_active, (mq.size() < 4), 3'(mq.size())});
      end
    end
    rst_a = 1'b0;
    ifa.tx_valid = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; bt_a = 1'b1; par_a = 2'b00; st2_a = 1'b0;
    ifa.tx_valid = 1'b0; ifa.d_in = '0;
    rst_b = 1'b1; bt_b = 1'b0; par_b = 2'b00; st2_b = 1'b0;
    ifb.tx_valid = 1'b0; ifb.d_in = '0;
    test_reset();
    test_frame_a5();
    test_parity();
    test_dbits7();
    test_fifo_fill();
    test_config_change();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO and runtime-selectable framing. It serialises DATA_BITS-wide words LSB-first with optional even/odd parity and one or two stop bits, advancing bit timing on an external baud tick. A small FIFO with a valid/ready write port lets the bus side queue several bytes and stream frames back-to-back. Sits between the bus-facing register block and the RS-232 pin, replacing the fixed 8-bit, always-parity transmitter.

## Interface

- OVERSAMPLE, 16: b_tick pulses per bit period; 2..256.
- DATA_BITS, 8: data bits per frame; 5..9.
- FIFO_DEPTH, 4: FIFO entries; power of two, ≥2.
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- b_tick  in  1  baud tick, one clk wide.
- tx_valid  in  1  write request.
- tx_ready  out  1  FIFO can accept; high when count < FIFO_DEPTH.
- d_in  in  DATA_BITS  write data.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- stop2  in  1  1 = two stop bits.
- tx  out  1  serial line, registered, idle high.
- tx_done  out  1  one-cycle pulse at end of last stop bit.
- busy  out  1  high in any state except IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words held.

## Operation

- Push on tx_valid && tx_ready; d_in stored. No push when full; tx_valid held by the writer.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. If fifo_count≠0, then at the clock edge:
  - pop the head into shift register;
  - latch parity_mode and stop2 into frame config;
  - compute parity from the popped word (even: XOR of bits; odd: inverted XOR);
  - tick_cnt←0, bit_cnt←0, tx←0, state←START.
- Config and data inputs are ignored mid-frame; only the latched copies are used.
- tick_cnt counts b_tick within the current bit. A b_tick with tick_cnt==OVERSAMPLE-1 ends the bit: tick_cnt←0, next bit value loaded into tx on the same edge. Otherwise tick_cnt increments. No b_tick → no change.
- START end → DATA, tx←shift[0].
- DATA end: shift right.
  - If bit_cnt==DATA_BITS-1, go to PARITY (tx←parity) when parity is enabled, else STOP (tx←1).
  - Otherwise bit_cnt++ and tx←next bit.
- PARITY end → STOP, tx←1, bit_cnt←0.
- STOP lasts 1 or 2 bit periods per latched stop2; bit_cnt counts stop bits.
- At the end of the last stop bit: state←IDLE, tx_done←1 for one cycle, tx stays 1.
- Push and pop in the same cycle: count unchanged, FIFO order preserved.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Reset: state IDLE, FIFO emptied (pointers, count 0), tx=1, tx_done=0, busy=0, tx_ready=1, counters 0. Reset mid-frame aborts the frame; tx is high on the cycle after reset is sampled.

## Timing

- Write → first start bit: the word pushed at edge N is popped at edge N+1, and tx falls at edge N+1 when IDLE.
- Frame length: (1 + DATA_BITS + P + S)·OVERSAMPLE b_ticks, where P∈{0,1} is the parity bit and S∈{1,2} is the stop-bit count.
- Back-to-back frames: one clk in IDLE between tx_done and the next start bit. tx remains high during that cycle.
- tx_done, busy, tx, tx_ready and fifo_count are all registered or derived from registered state. No combinational path from inputs to outputs.
- tx_ready rises the cycle after a pop from full.

## Test plan

- OVERSAMPLE=16, DATA_BITS=8, b_tick every clk, parity none, 1 stop, write 0xA5:
  - tx bits, each 16 clk: 0,1,0,1,0,0,1,0,1,1;
  - tx_done pulses 160 clk after tx falls;
  - busy high throughout.
- Parity: write 0x07 with even parity → parity bit 1; write 0x07 with odd parity → parity bit 0. Both frames are 11 bits (176 clk).
- DATA_BITS=7, odd parity, stop2=1, b_tick every 4th clk, write 0x55:
  - bit period 64 clk;
  - frame 11 bits = 704 clk;
  - parity bit 1;
  - both stop bits high.
- FIFO_DEPTH=4, six consecutive writes 0x01..0x06 starting cycle 0:
  - fifo_count reaches 4 after the 5th write;
  - tx_ready is low at the 6th write until the first frame completes, then 0x06 is accepted;
  - six frames are sent in order, with one idle clk between them.
- Change parity_mode and stop2 mid-frame → the current frame is unchanged; the next frame uses the new values.
- Assert reset during DATA bit 3 with 2 words queued:
  - tx=1 the next cycle;
  - fifo_count=0, tx_done never pulses;
  - no frame starts after reset deasserts.
